// File: rtl/mux_ser_pkg.sv
// Shared widths, state type and lane mapping for the 4:1 mux serializer.
// Build macro SER_PARITY_EN adds a trailing even-parity beat to every word.
package mux_ser_pkg;

   localparam int DATA_W = 4;
   localparam int SEL_W  = 2;
   localparam int IDX_W  = 3;

`ifdef SER_PARITY_EN
   localparam logic [IDX_W-1:0] LAST_IDX = 3'd4;
`else
   localparam logic [IDX_W-1:0] LAST_IDX = 3'd3;
`endif

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_t;

   // The parity beat (idx 4) parks the select on the last data lane.
   function automatic logic [SEL_W-1:0] lane_sel(input logic [IDX_W-1:0] idx,
                                                 input logic             msb_first);
      logic [SEL_W-1:0] lane;
      lane = (idx > 3'd3) ? 2'd3 : idx[SEL_W-1:0];
      return msb_first ? 2'(2'd3 - lane) : lane;
   endfunction

endpackage

// File: rtl/mux_4to1_if.sv
// Bare 4:1 bit-select mux; the serializer owns and drives its select.
module mux_4to1_if
   import mux_ser_pkg::*;
(
   input  logic [DATA_W-1:0] datain,
   input  logic [SEL_W-1:0]  select,
   output logic              outd
);

   assign outd = datain[select];

endmodule

// File: rtl/mux_4to1_serializer.sv
// Valid/ready parallel-to-serial stage: one 4-bit word in, one bit per beat out with framing.
// Build macro SER_PARITY_EN appends an even-parity beat after the four data beats.
module mux_4to1_serializer
   import mux_ser_pkg::*;
#(
   parameter bit MSB_FIRST  = 1'b0,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_bit,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_first,
   output logic              out_last,
   output logic [SEL_W-1:0]  sel_o,
   output logic              busy
);

   localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
   localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

   ser_state_t        state_q;
   logic [DATA_W-1:0] hold_q;
   logic [IDX_W-1:0]  idx_q;
   logic [3:0]        gap_q;
   logic              mux_bit;
   logic              fire;
   logic              last_fire;
   logic              accept;

   assign sel_o = (state_q == SHIFT) ? lane_sel(idx_q, MSB_FIRST) : '0;

   mux_4to1_if u_mux (
      .datain (hold_q),
      .select (sel_o),
      .outd   (mux_bit)
   );

   always_comb begin
      out_valid = (state_q == SHIFT);
      busy      = (state_q != IDLE);
      out_first = out_valid && (idx_q == '0);
      out_last  = out_valid && (idx_q == LAST_IDX);
      fire      = out_valid && out_ready;
      last_fire = fire && (idx_q == LAST_IDX);
      // Reload on the last beat is combinational from out_ready so back-to-back words lose no cycle.
      in_ready  = (state_q == IDLE) || (last_fire && !HAS_GAP);
      accept    = in_valid && in_ready;
   end

   always_comb begin
      // NOTE: assign a default before any conditional override so no latch is inferred.
      out_bit = mux_bit;
`ifdef SER_PARITY_EN
      if (idx_q == LAST_IDX) out_bit = ^hold_q;
`endif
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  hold_q  <= in_data;
                  idx_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (last_fire) begin
                  idx_q <= '0;
                  if (HAS_GAP) begin
                     state_q <= GAP;
                     gap_q   <= '0;
                  end else if (accept) begin
                     hold_q <= in_data;
                  end else begin
                     state_q <= IDLE;
                  end
               end else if (fire) begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            GAP: begin
               if (gap_q == GAP_LAST) state_q <= IDLE;
               else                   gap_q   <= gap_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_4to1_serializer.sv
// Bench for mux_4to1_serializer: three configurations (LSB-first, MSB-first, 2-cycle gap)
// share stimulus; a queue-based beat model is compared every cycle, plus literal word checks.
module tb_mux_4to1_serializer;
   import mux_ser_pkg::*;

`ifdef SER_PARITY_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif
   localparam int N_INST = 3;

   typedef struct packed {
      logic       b;
      logic [1:0] s;
      logic       f;
      logic       l;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] in_data = 4'd0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;

   logic       ir [N_INST];
   logic       ob [N_INST];
   logic       ov [N_INST];
   logic       of [N_INST];
   logic       ol [N_INST];
   logic       by [N_INST];
   logic [1:0] so [N_INST];

   int    n_checks = 0;
   int    n_errors = 0;
   bit    en = 1'b0;
   int    cyc = 0;
   int    gap_seen = 0;
   beat_t mq [N_INST][$];
   int    gap_left [N_INST];
   int    acc_cnt [N_INST];
   beat_t lq [N_INST][$];
   int    lcyc [N_INST][$];

   mux_4to1_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
      .out_bit(ob[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_first(of[0]),
      .out_last(ol[0]), .sel_o(so[0]), .busy(by[0]));

   mux_4to1_serializer #(.MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
      .out_bit(ob[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_first(of[1]),
      .out_last(ol[1]), .sel_o(so[1]), .busy(by[1]));

   mux_4to1_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
      .out_bit(ob[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_first(of[2]),
      .out_last(ol[2]), .sel_o(so[2]), .busy(by[2]));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic bit inst_msb(input int i);
      return (i == 1);
   endfunction

   function automatic int inst_gap(input int i);
      return (i == 2) ? 2 : 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a word becomes NB queued beats; the stage is free when no beats and no gap remain.
   function automatic bit model_ready(input int i);
      return (mq[i].size() == 0 && gap_left[i] == 0) ||
             (mq[i].size() == 1 && out_ready && inst_gap(i) == 0);
   endfunction

   function automatic void push_word(input int i, input logic [3:0] w);
      for (int k = 0; k < NB; k++) begin
         int    lane;
         beat_t bt;
         lane = (k > 3) ? 3 : k;
         bt.s = inst_msb(i) ? 2'(3 - lane) : 2'(lane);
         bt.b = (k == 4) ? ^w : w[bt.s];
         bt.f = (k == 0);
         bt.l = (k == NB - 1);
         mq[i].push_back(bt);
      end
   endfunction

   function automatic bit all_idle();
      bit idle;
      idle = 1'b1;
      for (int i = 0; i < N_INST; i++)
         if (mq[i].size() != 0 || gap_left[i] != 0) idle = 1'b0;
      return idle;
   endfunction

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < N_INST; i++) begin
         bit acc;
         bit fire;
         if (rst) begin
            mq[i].delete();
            gap_left[i] = 0;
         end else begin
            acc  = in_valid && model_ready(i);
            fire = (mq[i].size() != 0) && out_ready;
            if (gap_left[i] > 0) gap_left[i]--;
            if (fire) begin
               void'(mq[i].pop_front());
               if (mq[i].size() == 0 && inst_gap(i) > 0) gap_left[i] = inst_gap(i);
            end
            if (acc) begin
               push_word(i, in_data);
               acc_cnt[i]++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (en) begin
         for (int i = 0; i < N_INST; i++) begin
            bit exp_v;
            exp_v = (mq[i].size() != 0);
            check($sformatf("inst%0d out_valid", i), 32'(ov[i]), 32'(exp_v));
            check($sformatf("inst%0d busy", i), 32'(by[i]), 32'(exp_v || gap_left[i] > 0));
            check($sformatf("inst%0d in_ready", i), 32'(ir[i]), 32'(model_ready(i)));
            if (exp_v) begin
               check($sformatf("inst%0d out_bit", i), 32'(ob[i]), 32'(mq[i][0].b));
               check($sformatf("inst%0d sel_o", i), 32'(so[i]), 32'(mq[i][0].s));
               check($sformatf("inst%0d out_first", i), 32'(of[i]), 32'(mq[i][0].f));
               check($sformatf("inst%0d out_last", i), 32'(ol[i]), 32'(mq[i][0].l));
            end
            if (!rst && ov[i] && out_ready) begin
               beat_t bt;
               bt.b = ob[i];
               bt.s = so[i];
               bt.f = of[i];
               bt.l = ol[i];
               lq[i].push_back(bt);
               lcyc[i].push_back(cyc);
            end
            if (i == 2 && by[2] && !ov[2]) gap_seen++;
         end
      end
   end

   task automatic clear_logs();
      for (int i = 0; i < N_INST; i++) begin
         lq[i].delete();
         lcyc[i].delete();
      end
      gap_seen = 0;
   endtask

   task automatic send_word(input logic [3:0] w);
      in_data  = w;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if (all_idle()) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check({name, " drain"}, 32'(ok), 32'd1);
   endtask

   // Beat k of the log sits at exp_b[k] and exp_s[2k+:2]; framing repeats every NB beats.
   task automatic check_log(input int i, input string name, input logic [9:0] exp_b,
                            input logic [19:0] exp_s, input int n);
      check({name, " beats"}, 32'(lq[i].size()), 32'(n));
      for (int k = 0; k < n && k < lq[i].size(); k++) begin
         check($sformatf("%s bit%0d", name, k), 32'(lq[i][k].b), 32'(exp_b[k]));
         check($sformatf("%s sel%0d", name, k), 32'(lq[i][k].s), 32'(exp_s[2*k +: 2]));
         check($sformatf("%s first%0d", name, k), 32'(lq[i][k].f), 32'(k % NB == 0));
         check($sformatf("%s last%0d", name, k), 32'(lq[i][k].l), 32'(k % NB == NB - 1));
      end
   endtask

   initial begin
      logic [19:0] t4_sels;
      int          b0;
      int          b1;
      int          b2;
      for (int i = 0; i < N_INST; i++) begin
         gap_left[i] = 0;
         acc_cnt[i]  = 0;
      end

      // 1: reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      en  = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N_INST; i++) begin
         check($sformatf("t1 inst%0d in_ready", i), 32'(ir[i]), 32'd1);
         check($sformatf("t1 inst%0d out_valid", i), 32'(ov[i]), 32'd0);
         check($sformatf("t1 inst%0d sel_o", i), 32'(so[i]), 32'd0);
         check($sformatf("t1 inst%0d busy", i), 32'(by[i]), 32'd0);
      end
      @(posedge clk);
      #1;

      // 2: single word, LSB-first and MSB-first views
      clear_logs();
      send_word(4'b0001);
      wait_idle("t2");
      check_log(0, "t2 lsb", {5'd0, 5'b10001}, {10'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0}, NB);
      check_log(1, "t2 msb", {5'd0, 5'b11000}, {10'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3}, NB);

      // 3: consumer stalls three cycles on beat 1
      clear_logs();
      send_word(4'b1010);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t3 stall valid", 32'(ov[0]), 32'd1);
         check("t3 stall bit", 32'(ob[0]), 32'd1);
         check("t3 stall sel", 32'(so[0]), 32'd1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_idle("t3");
      check_log(0, "t3", {5'd0, 5'b01010}, {10'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0}, NB);

      // 4: back-to-back words with in_valid held
      clear_logs();
      b0 = acc_cnt[0];
      b1 = acc_cnt[1];
      b2 = acc_cnt[2];
      in_data  = 4'b1111;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_data = 4'b0000;
      for (int t = 0; t < 100; t++) begin
         if (acc_cnt[0] >= b0 + 2 && acc_cnt[1] >= b1 + 2 && acc_cnt[2] >= b2 + 2) break;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_idle("t4");
`ifdef SER_PARITY_EN
      t4_sels = {2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
`else
      t4_sels = {2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
`endif
      check_log(0, "t4", 10'b0000001111, t4_sels, 2 * NB);
      if (lcyc[0].size() == 2 * NB)
         check("t4 no bubble span", 32'(lcyc[0][2*NB-1] - lcyc[0][0]), 32'(2 * NB - 1));
      check("t4 gap cycles", 32'(gap_seen), 32'd4);

      // 5: MSB-first word
      clear_logs();
      send_word(4'b1000);
      wait_idle("t5");
      check_log(1, "t5", {5'd0, 5'b10001}, {10'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3}, NB);

      // 6: reset in the middle of a word
      clear_logs();
      send_word(4'b0110);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N_INST; i++) begin
         check($sformatf("t6 inst%0d out_valid", i), 32'(ov[i]), 32'd0);
         check($sformatf("t6 inst%0d busy", i), 32'(by[i]), 32'd0);
      end
      @(posedge clk);
      #1;
      clear_logs();
      send_word(4'b0110);
      wait_idle("t6");
      check_log(0, "t6", {5'd0, 5'b00110}, {10'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0}, NB);

      // 7: word whose parity beat is 1
      clear_logs();
      send_word(4'b0111);
      wait_idle("t7");
      check_log(0, "t7", {5'd0, 5'b10111}, {10'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0}, NB);

      // Random traffic with back-pressure and occasional reset
      for (int n = 0; n < 1500; n++) begin
         in_data   = 4'($urandom);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 99) == 0);
         @(posedge clk);
         #1;
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_idle("random");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
